i_fetch: RTL and testbench

Instruction-fetch stage of the five-stage pipeline, sitting ahead of `i_decode`. It owns the program counter, drives the instruction-memory address, and registers the IF/ID pair (`instruction`, `pc_plus_four`) that decode consumes. It accepts the redirect (`jump_or_branch`, `target`) and multi-cycle lock request (`reg_lock_if`) that decode produces. It also accepts a global `stall` hold from the hazard unit.

---
 rtl/i_fetch.sv | 68 ++++++
 tb/tb_i_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_fetch.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and registers the IF/ID pair.
// Optional build macro IF_DELAY_SLOT_EN: a redirect edge keeps the delay-slot word instead of a NOP.
module i_fetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter logic [31:0] NOP      = 32'h00000015
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        jump_or_branch,
   input  logic [31:0] target,
   input  logic        reg_lock_if,
   input  logic [3:0]  lock_len,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] instruction,
   output logic [31:0] pc_plus_four,
   output logic        lock_busy
);

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] LOCK = 1'b1;

   logic [0:0]  state;
   logic [3:0]  cnt;
   logic [31:0] pc;
   logic [31:0] pc_next_seq;

   assign pc_next_seq = pc + 32'd4;
   assign imem_addr   = pc;
   assign lock_busy   = (state == LOCK);

   // A lock of N edges spends its first edge in RUN, so LOCK only covers the remaining N-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= RESET_PC;
         instruction  <= NOP;
         pc_plus_four <= 32'h00000000;
         state        <= RUN;
         cnt          <= 4'd0;
      end else if (!stall) begin
         if (state == LOCK) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
               state <= RUN;
            end
         end else if (jump_or_branch) begin
            pc           <= target;
            pc_plus_four <= pc_next_seq;
`ifdef IF_DELAY_SLOT_EN
            instruction  <= imem_data;
`else
            instruction  <= NOP;
`endif
         end else if (reg_lock_if) begin
            if (lock_len > 4'd1) begin
               state <= LOCK;
               cnt   <= lock_len - 4'd1;
            end
         end else begin
            instruction  <= imem_data;
            pc_plus_four <= pc_next_seq;
            pc           <= pc_next_seq;
         end
      end
   end

endmodule

// File: tb/tb_i_fetch.sv
// Self-checking bench for i_fetch: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural fetch model.
module tb_i_fetch;

   localparam logic [31:0] NOP_WORD = 32'h00000015;
   localparam logic [31:0] MEM_BASE = 32'h20000000;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        jump_or_branch;
   logic [31:0] target;
   logic        reg_lock_if;
   logic [3:0]  lock_len;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] instruction;
   logic [31:0] pc_plus_four;
   logic        lock_busy;

   int tests_run;
   int tests_failed;

   // Behavioural model: architectural PC, IF/ID pair, and number of hold edges still owed
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_ppf;
   int          m_hold_left;

   i_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .jump_or_branch (jump_or_branch),
      .target         (target),
      .reg_lock_if    (reg_lock_if),
      .lock_len       (lock_len),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .instruction    (instruction),
      .pc_plus_four   (pc_plus_four),
      .lock_busy      (lock_busy)
   );

   assign imem_data = MEM_BASE + imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return MEM_BASE + a;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic modelReset();
      m_pc        = 32'h00000000;
      m_instr     = NOP_WORD;
      m_ppf       = 32'h00000000;
      m_hold_left = 0;
   endtask

   task automatic checkOutput();
      checkValue("model imem_addr", imem_addr, m_pc);
      checkValue("model instruction", instruction, m_instr);
      checkValue("model pc_plus_four", pc_plus_four, m_ppf);
      checkValue("model lock_busy", {31'd0, lock_busy}, {31'd0, (m_hold_left > 0)});
   endtask

   // Drive one cycle of inputs, advance the model on the edge, then compare mid-cycle
   task automatic applyStimulus(input logic s, input logic jb, input logic [31:0] tgt,
                                input logic lk, input logic [3:0] len);
      stall          = s;
      jump_or_branch = jb;
      target         = tgt;
      reg_lock_if    = lk;
      lock_len       = len;
      @(posedge clk);
      if (!s) begin
         if (m_hold_left > 0) begin
            m_hold_left--;
         end else if (jb) begin
            m_ppf = m_pc + 32'd4;
`ifdef IF_DELAY_SLOT_EN
            m_instr = memWord(m_pc);
`else
            m_instr = NOP_WORD;
`endif
            m_pc = tgt;
         end else if (lk) begin
            m_hold_left = (len <= 4'd1) ? 0 : int'(len) - 1;
         end else begin
            m_instr = memWord(m_pc);
            m_ppf   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
         end
      end
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 4'd0);
   endtask

   initial begin
      logic [31:0] saved_addr;
      logic [31:0] saved_instr;
      logic [31:0] saved_ppf;
      int          busy_cycles;
      logic        s;
      logic        jb;
      logic        lk;
      logic [31:0] tgt;
      logic [3:0]  len;

      tests_run      = 0;
      tests_failed   = 0;
      rst_n          = 1'b0;
      stall          = 1'b0;
      jump_or_branch = 1'b0;
      target         = 32'h0;
      reg_lock_if    = 1'b0;
      lock_len       = 4'd0;
      modelReset();

      // Reset values
      repeat (2) @(negedge clk);
      checkValue("reset imem_addr", imem_addr, 32'h00000000);
      checkValue("reset instruction", instruction, 32'h00000015);
      checkValue("reset pc_plus_four", pc_plus_four, 32'h00000000);
      checkValue("reset lock_busy", {31'd0, lock_busy}, 32'd0);
      rst_n = 1'b1;

      // Sequential fetch
      idle();
      checkValue("seq0 instruction", instruction, 32'h20000000);
      checkValue("seq0 pc_plus_four", pc_plus_four, 32'h00000004);
      idle();
      checkValue("seq1 instruction", instruction, 32'h20000004);
      checkValue("seq1 pc_plus_four", pc_plus_four, 32'h00000008);
      checkValue("seq1 imem_addr", imem_addr, 32'h00000008);

      // Redirect at pc 8
      applyStimulus(1'b0, 1'b1, 32'h00000100, 1'b0, 4'd0);
      checkValue("redirect imem_addr", imem_addr, 32'h00000100);
      checkValue("redirect pc_plus_four", pc_plus_four, 32'h0000000C);
`ifdef IF_DELAY_SLOT_EN
      checkValue("redirect instruction", instruction, 32'h20000008);
`else
      checkValue("redirect instruction", instruction, 32'h00000015);
`endif

      // Lock of 3 at pc 0x10
      applyStimulus(1'b0, 1'b1, 32'h00000010, 1'b0, 4'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'd3);
      checkValue("lock3 addr c1", imem_addr, 32'h00000010);
      checkValue("lock3 busy c1", {31'd0, lock_busy}, 32'd1);
      idle();
      checkValue("lock3 addr c2", imem_addr, 32'h00000010);
      checkValue("lock3 busy c2", {31'd0, lock_busy}, 32'd1);
      idle();
      checkValue("lock3 addr c3", imem_addr, 32'h00000010);
      checkValue("lock3 busy c3", {31'd0, lock_busy}, 32'd0);
      idle();
      checkValue("lock3 addr after", imem_addr, 32'h00000014);
      checkValue("lock3 instr after", instruction, 32'h20000010);

      // Lock lengths 0 and 1 hold exactly one edge
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'd0);
      checkValue("lock0 addr", imem_addr, 32'h00000014);
      checkValue("lock0 busy", {31'd0, lock_busy}, 32'd0);
      idle();
      checkValue("lock0 advance", imem_addr, 32'h00000018);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'd1);
      checkValue("lock1 addr", imem_addr, 32'h00000018);
      checkValue("lock1 busy", {31'd0, lock_busy}, 32'd0);
      idle();
      checkValue("lock1 advance", imem_addr, 32'h0000001C);

      // Redirect and lock together: redirect wins, no lock
      applyStimulus(1'b0, 1'b1, 32'h00000040, 1'b1, 4'd5);
      checkValue("both addr", imem_addr, 32'h00000040);
      checkValue("both busy", {31'd0, lock_busy}, 32'd0);
      idle();
      checkValue("both advance", imem_addr, 32'h00000044);

      // Stall with both requests: nothing changes
      saved_addr  = imem_addr;
      saved_instr = instruction;
      saved_ppf   = pc_plus_four;
      applyStimulus(1'b1, 1'b1, 32'h00000300, 1'b1, 4'd7);
      checkValue("stall addr", imem_addr, saved_addr);
      checkValue("stall instruction", instruction, saved_instr);
      checkValue("stall pc_plus_four", pc_plus_four, saved_ppf);
      checkValue("stall busy", {31'd0, lock_busy}, 32'd0);

      // Stall for 5 cycles inside a lock of 4: busy lasts 3 + 5 cycles
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'd4);
      saved_addr  = imem_addr;
      busy_cycles = 0;
      for (int i = 0; i < 30; i++) begin
         if (!lock_busy) break;
         busy_cycles++;
         applyStimulus((i >= 1 && i <= 5), 1'b0, 32'h0, 1'b0, 4'd0);
      end
      checkValue("stalled lock busy cycles", busy_cycles, 32'd8);
      checkValue("stalled lock addr held", imem_addr, saved_addr);

      // Wrap around the top of the address space
      applyStimulus(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 4'd0);
      idle();
      checkValue("wrap imem_addr", imem_addr, 32'h00000000);
      checkValue("wrap pc_plus_four", pc_plus_four, 32'h00000000);
      checkValue("wrap instruction", instruction, 32'h1FFFFFFC);

      // Asynchronous reset in the middle of a lock
      applyStimulus(1'b0, 1'b1, 32'h00000200, 1'b0, 4'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 4'd6);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      checkValue("async instruction", instruction, 32'h00000015);
      checkValue("async busy", {31'd0, lock_busy}, 32'd0);
      checkValue("async imem_addr", imem_addr, 32'h00000000);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      checkValue("post-reset instruction", instruction, 32'h20000000);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         s   = ($urandom_range(0, 9) == 0);
         jb  = ($urandom_range(0, 7) == 0);
         lk  = ($urandom_range(0, 5) == 0);
         tgt = $urandom();
         if ($urandom_range(0, 1) == 1) tgt[1:0] = 2'b00;
         len = 4'($urandom_range(0, 15));
         applyStimulus(s, jb, tgt, lk, len);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
